// File: rtl/ascii_stream_to_bcd16_pkg.sv
// ============================================================================
// ascii_stream_to_bcd16_pkg : shared ASCII constants and state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package ascii_stream_to_bcd16_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_CR   = 8'h0D;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    RX   = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ascii_digit_decode.sv
// ============================================================================
// ascii_digit_decode : classifies one ASCII char as a decimal digit
// Rev 1.0
// ============================================================================
`default_nettype none

module ascii_digit_decode
  import ascii_stream_to_bcd16_pkg::*;
(
  input  logic [7:0]          ch,
  output logic                is_digit,
  output logic [NIBBLE_W-1:0] nibble
);

  assign is_digit = (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
  assign nibble   = ch[NIBBLE_W-1:0];

endmodule

`default_nettype wire

// File: rtl/ascii_stream_to_bcd16.sv
// ============================================================================
// ascii_stream_to_bcd16 : packs a CR-terminated ASCII digit stream into BCD
// Rev 1.0
// ============================================================================
`default_nettype none

module ascii_stream_to_bcd16
  import ascii_stream_to_bcd16_pkg::*;
#(
  parameter int         DIGITS    = 4,
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter int         CNT_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   in_char,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [NIBBLE_W*DIGITS-1:0]   bcd_out,
  output logic [CNT_W-1:0]             digit_cnt,
  output logic                         err,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int              ACC_W   = NIBBLE_W * DIGITS;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DIGITS);

  state_t                state;
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      count;
  logic                  err_sticky;
  logic                  is_digit;
  logic [NIBBLE_W-1:0]   nibble;

  ascii_digit_decode u_decode (
    .ch       (in_char),
    .is_digit (is_digit),
    .nibble   (nibble)
  );

  assign in_ready  = (state == RX);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX;
      acc        <= '0;
      count      <= '0;
      err_sticky <= 1'b0;
      bcd_out    <= '0;
      digit_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        RX: begin
          if (in_valid) begin
            if (in_char == TERM_CHAR) begin
              state     <= DONE;
              bcd_out   <= err_sticky ? '0 : acc;
              digit_cnt <= count;
              err       <= err_sticky;
            end else if (is_digit) begin
              // Once a frame is bad, further digits are swallowed silently.
              if (!err_sticky) begin
                if (count == MAX_CNT) begin
                  err_sticky <= 1'b1;
                end else begin
                  acc   <= {acc[ACC_W-NIBBLE_W-1:0], nibble};
                  count <= count + 1'b1;
                end
              end
            end else begin
              err_sticky <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state      <= RX;
            acc        <= '0;
            count      <= '0;
            err_sticky <= 1'b0;
          end
        end
        default: state <= RX;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ascii_stream_to_bcd16.sv
// ============================================================================
// tb_ascii_stream_to_bcd16 : directed self-checking bench
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ascii_stream_to_bcd16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] bcd_out;
  logic [2:0]  digit_cnt;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int pass_cnt = 0;
  int total    = 0;

  // {out_valid, err, digit_cnt, bcd_out}
  logic [20:0] got;

  ascii_stream_to_bcd16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_char   (in_char),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .digit_cnt (digit_cnt),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic send_char(input logic [7:0] c);
    int n = 0;
    in_char  = c;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_timeout char=%h in_ready=%b required=1", c, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL %s_release out_valid,in_ready=%b required=01", name, {out_valid, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== 21'h0) $display("FAIL reset_outputs got=%h required=%h", got, 21'h0);
    else pass_cnt++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b required=1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send_char("1"); send_char("2"); send_char("3"); send_char("4");
    send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b0, 3'd4, 16'h1234})
      $display("FAIL basic_1234 got=%h required=%h", got, {1'b1, 1'b0, 3'd4, 16'h1234});
    else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, bcd_out} !== {2'b01, 16'h1234})
      $display("FAIL basic_after_xfer got=%h required=%h", {out_valid, in_ready, bcd_out}, {2'b01, 16'h1234});
    else pass_cnt++;
  endtask

  task automatic test_short_frames();
    send_char("4"); send_char("2"); send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b0, 3'd2, 16'h0042})
      $display("FAIL frame_42 got=%h required=%h", got, {1'b1, 1'b0, 3'd2, 16'h0042});
    else pass_cnt++;
    release_result("frame_42");
    send_char("7"); send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b0, 3'd1, 16'h0007})
      $display("FAIL frame_7 got=%h required=%h", got, {1'b1, 1'b0, 3'd1, 16'h0007});
    else pass_cnt++;
    release_result("frame_7");
  endtask

  task automatic test_bad_char();
    send_char("1"); send_char("A");
    total++;
    if (in_ready !== 1'b1) $display("FAIL bad_char_still_ready got=%b required=1", in_ready);
    else pass_cnt++;
    send_char("3"); send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b1, 3'd1, 16'h0000})
      $display("FAIL bad_char got=%h required=%h", got, {1'b1, 1'b1, 3'd1, 16'h0000});
    else pass_cnt++;
    release_result("bad_char");
  endtask

  task automatic test_overflow();
    send_char("9"); send_char("8"); send_char("7"); send_char("6"); send_char("5");
    send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b1, 3'd4, 16'h0000})
      $display("FAIL overflow got=%h required=%h", got, {1'b1, 1'b1, 3'd4, 16'h0000});
    else pass_cnt++;
    release_result("overflow");
    send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b0, 3'd0, 16'h0000})
      $display("FAIL empty_frame got=%h required=%h", got, {1'b1, 1'b0, 3'd0, 16'h0000});
    else pass_cnt++;
    release_result("empty_frame");
  endtask

  task automatic test_backpressure();
    int bad = 0;
    out_ready = 1'b0;
    send_char("5"); send_char(8'h0D);
    in_char  = "6";
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, in_ready, err, digit_cnt, bcd_out} !== {3'b100, 3'd1, 16'h0005}) bad++;
      @(posedge clk); #1;
    end
    total++;
    if (bad != 0) $display("FAIL hold_stable bad_cycles=%0d required=0", bad);
    else pass_cnt++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL hold_release out_valid,in_ready=%b required=01", {out_valid, in_ready});
    else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b0, 3'd1, 16'h0006})
      $display("FAIL held_char_once got=%h required=%h", got, {1'b1, 1'b0, 3'd1, 16'h0006});
    else pass_cnt++;
    release_result("held_char");
  endtask

  task automatic test_reset_midframe();
    send_char("1"); send_char("2");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if ({got, in_ready} !== 22'h1)
      $display("FAIL midframe_reset got=%h required=%h", {got, in_ready}, 22'h1);
    else pass_cnt++;
    send_char("3"); send_char(8'h0D);
    got = {out_valid, err, digit_cnt, bcd_out};
    total++;
    if (got !== {1'b1, 1'b0, 3'd1, 16'h0003})
      $display("FAIL after_reset got=%h required=%h", got, {1'b1, 1'b0, 3'd1, 16'h0003});
    else pass_cnt++;
    release_result("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frames();
    test_bad_char();
    test_overflow();
    test_backpressure();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
